// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Function : Queues ALU commands, drives operands to an external ALU, waits
//            SETTLE_CYCLES, captures the result and presents it as a response.
//            Optional macro ALU_DRV_CHAIN_EN enables result chaining into A.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_chain,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_res,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_seq,
    output logic [3:0] err_count,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [2:0]  SETTLE_LOAD = 3'(SETTLE_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [3:0] fifo_op [DEPTH];
    logic [3:0] fifo_a  [DEPTH];
    logic [3:0] fifo_b  [DEPTH];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          load;
    logic [1:0]    state;
    logic [2:0]    settle_cnt;
    logic [3:0]    head_a;

    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    // A pop happens exactly when a new command is loaded onto the ALU.
    assign load      = !empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
    assign busy      = (state != S_IDLE) || !empty;

`ifdef ALU_DRV_CHAIN_EN
    logic       fifo_chain [DEPTH];
    logic [3:0] last_res;

    assign head_a = fifo_chain[rd_idx] ? last_res : fifo_a[rd_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_chain[wr_idx] <= cmd_chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_res <= 4'd0;
        end else if ((state == S_DRIVE) && (settle_cnt == 3'd1)) begin
            last_res <= alu_res[3:0];
        end
    end
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign head_a       = fifo_a[rd_idx];
`endif

    // Storage needs no reset: only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_idx] <= cmd_op;
            fifo_a[wr_idx]  <= cmd_a;
            fifo_b[wr_idx]  <= cmd_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= S_IDLE;
            settle_cnt <= 3'd0;
            alu_op     <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_seq    <= 4'd0;
            err_count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                alu_op     <= fifo_op[rd_idx];
                alu_a      <= head_a;
                alu_b      <= fifo_b[rd_idx];
                settle_cnt <= SETTLE_LOAD;
            end
            case (state)
                S_IDLE: begin
                    if (load) begin
                        state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == 3'd1) begin
                        rsp_data  <= alu_res;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                        if (alu_res[4] && (err_count != 4'hF)) begin
                            err_count <= err_count + 4'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_seq   <= rsp_seq + 4'd1;
                        state     <= load ? S_DRIVE : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Function : Self-checking bench for alu_cmd_driver with a behavioural ALU and
//            an in-order response model (honours ALU_DRV_CHAIN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

`ifdef ALU_DRV_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic       cmd_chain = 1'b0;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_res;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_seq;
    logic [3:0] err_count;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic [3:0] seq_model  = 4'd0;
    logic [3:0] last_model = 4'd0;
    int         err_model  = 0;

    always #5 clk = ~clk;

    // Packed {Zero, Carry, Sign, Error, Result}; division by zero flags Error.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        logic       e;
        e = 1'b0;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a & b};
            4'd3: begin
                if (b == 4'd0) begin
                    e = 1'b1;
                    r = 5'd0;
                end else begin
                    r = {1'b0, a / b};
                end
            end
            default: r = {1'b0, a ^ b};
        endcase
        return {(r[3:0] == 4'd0), r[4], r[3], e, r[3:0]};
    endfunction

    function automatic logic [3:0] sat15(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);

    alu_cmd_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_seq   (rsp_seq),
        .err_count (err_count),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        seq_model  = 4'd0;
        last_model = 4'd0;
        err_model  = 0;
    endtask

    // One clock: check any presented response, advance, then apply handshakes to the model.
    task automatic tick();
        logic       push;
        logic       pop;
        logic [3:0] a_eff;
        logic [7:0] r;
        push = cmd_valid && cmd_ready;
        pop  = rsp_valid && rsp_ready;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 16'd1, 16'd0);
            end else begin
                check("rsp_data", 16'(rsp_data), 16'(exp_q[0]));
                check("rsp_seq", 16'(rsp_seq), 16'(seq_model));
                check("err_count", 16'(err_count), 16'(sat15(err_model + int'(exp_q[0][4]))));
            end
        end
        @(posedge clk);
        #1;
        if (push) begin
            a_eff = (CHAIN_EN && cmd_chain) ? last_model : cmd_a;
            r = alu_f(cmd_op, a_eff, cmd_b);
            exp_q.push_back(r);
            last_model = r[3:0];
        end
        if (pop && (exp_q.size() > 0)) begin
            err_model = err_model + int'(exp_q[0][4]);
            if (err_model > 15) err_model = 15;
            void'(exp_q.pop_front());
            seq_model = seq_model + 4'd1;
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_model();
        rst = 1'b0;
        #1;
    endtask

    task automatic run_one(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) check("cmd_ready_timeout", 16'd0, 16'd1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin tick(); n++; end
        if (n >= 50) check("rsp_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_alu", 16'({alu_op, alu_a, alu_b}), 16'd0);
        check("rst_rsp_data_seq", 16'({rsp_data, rsp_seq}), 16'd0);
        check("rst_err_busy", 16'({err_count, busy}), 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 16'(cmd_ready), 16'd1);

        // Single add, latency from accept edge
        rsp_ready = 1'b1;
        cmd_op = 4'd0; cmd_a = 4'd3; cmd_b = 4'd5; cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_e0_valid", 16'(rsp_valid), 16'd0);
        check("lat_e0_busy", 16'(busy), 16'd1);
        tick();
        check("lat_e1_valid", 16'(rsp_valid), 16'd0);
        check("lat_e1_alu", 16'({alu_op, alu_a, alu_b}), 16'h0035);
        tick();
        check("lat_e2_valid", 16'(rsp_valid), 16'd1);
        check("lat_e2_data", 16'(rsp_data), 16'h0028);
        check("lat_e2_seq", 16'(rsp_seq), 16'd0);
        tick();
        check("lat_e3_valid", 16'(rsp_valid), 16'd0);
        check("lat_e3_seq", 16'(rsp_seq), 16'd1);
        check("lat_e3_busy", 16'(busy), 16'd0);
        check("hold_alu", 16'({alu_op, alu_a, alu_b}), 16'h0035);

        // Divide by zero: error flag and saturation (17 commands, seq wraps)
        run_one(4'd3, 4'd7, 4'd0, 1'b0);
        check("div0_data", 16'(rsp_data), 16'h0090);
        check("div0_err1", 16'(err_count), 16'd1);
        for (int i = 0; i < 16; i++) run_one(4'd3, 4'd7, 4'd0, 1'b0);
        check("err_sat", 16'(err_count), 16'd15);
        check("seq_wrap", 16'(rsp_seq), 16'd2);

        // Back-pressure: fill RESP + FIFO, then drain in order
        do_reset();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_op = 4'd0; cmd_a = 4'(i); cmd_b = 4'd1; cmd_chain = 1'b0;
            check("fill_ready", 16'(cmd_ready), (i < 5) ? 16'd1 : 16'd0);
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("fill_queued", 16'(exp_q.size()), 16'd5);
        rsp_ready = 1'b1;
        for (int n = 0; n < 40 && (exp_q.size() != 0 || busy); n++) tick();
        check("drain_seq", 16'(rsp_seq), 16'd5);
        check("drain_busy", 16'(busy), 16'd0);

        // Chaining
        run_one(4'd0, 4'd2, 4'd3, 1'b0);
        check("chain_first", 16'(rsp_data), 16'h0005);
        run_one(4'd0, 4'd0, 4'd4, 1'b1);
        check("chain_second", 16'(rsp_data), CHAIN_EN ? 16'h0029 : 16'h0004);

        // Reset mid-RESP with 3 queued
        do_reset();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_op = 4'd1; cmd_a = 4'd9; cmd_b = 4'(i); cmd_chain = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_valid", 16'(rsp_valid), 16'd1);
        check("pre_rst_queued", 16'(exp_q.size()), 16'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 16'(rsp_valid), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_ready", 16'(cmd_ready), 16'd0);
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 16'({rsp_valid, busy}), 16'd0);
        run_one(4'd0, 4'd1, 4'd1, 1'b0);
        check("post_rst_seq", 16'(rsp_seq), 16'd1);

        // Randomized traffic against the in-order model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 4'($urandom_range(0, 5));
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 15));
            cmd_chain = ($urandom_range(0, 1) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 100 && (exp_q.size() != 0 || busy); n++) tick();
        check("rand_drained", 16'(exp_q.size()), 16'd0);
        check("rand_busy", 16'(busy), 16'd0);
        check("rand_seq", 16'(rsp_seq), 16'(seq_model));
        check("rand_err", 16'(err_count), 16'(sat15(err_model)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
